audio_mix_seq: RTL

- Time-multiplexed stereo audio mixer and sequencer for the MSX sound sources: OPLL, OPL3, two SCC channels, PSG, turbo-R PCM and tape.
- On each sample strobe it snapshots all sources, walks them through one shared L/R accumulator pair, saturates and presents a 16-bit signed stereo sample.
- It replaces the wide combinational sum in front of the volume control / I2S / DAC path.

---
 rtl/audio_mix_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_mix_seq.sv
// Time-multiplexed stereo mixer: snapshots all sound sources on sample_stb, accumulates them in
// eight single-cycle steps, saturates to 16 bits. Optional attenuation stage: AUDIO_MIX_VOL_EN.
module audio_mix_seq #(
    parameter int ACC_W     = 20,
    parameter int PSG_SHIFT = 6
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               sample_stb,
    input  logic signed [15:0] opll_i,
    input  logic signed [15:0] opl3_l_i,
    input  logic signed [15:0] opl3_r_i,
    input  logic signed [14:0] scc1_l_i,
    input  logic signed [14:0] scc1_r_i,
    input  logic signed [14:0] scc2_l_i,
    input  logic signed [14:0] scc2_r_i,
    input  logic        [8:0]  psg_i,
    input  logic signed [7:0]  pcm_i,
    input  logic               tape_i,
    input  logic        [6:0]  mute_mask,
    input  logic        [2:0]  vol_i,
    input  logic               clip_clr,
    output logic signed [15:0] out_l,
    output logic signed [15:0] out_r,
    output logic               out_valid,
    output logic               busy,
    output logic               clip_l,
    output logic               clip_r,
    output logic               stb_drop
);

    if (ACC_W < 19) begin : g_acc_w_check
        $error("audio_mix_seq: ACC_W must be >= 19");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;
`ifdef AUDIO_MIX_VOL_EN
    localparam logic [1:0] ST_VOL  = 2'd3;
`endif

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    logic [1:0]               state;
    logic [2:0]               idx;
    logic signed [ACC_W-1:0]  acc_l, acc_r;

    logic signed [15:0] opll_h, opl3_l_h, opl3_r_h;
    logic signed [14:0] scc1_l_h, scc1_r_h, scc2_l_h, scc2_r_h;
    logic        [8:0]  psg_h;
    logic signed [7:0]  pcm_h;
    logic               tape_h;
    logic        [6:0]  mute_h;

    logic signed [ACC_W-1:0] term_l, term_r;
    logic signed [15:0]      pcm_w;
    logic        [7:0]       mute_x;
    logic signed [15:0]      sat_l, sat_r;
    logic                    ovf_l, ovf_r;
    logic                    stb_accept;

    assign busy       = (state != ST_IDLE);
    assign stb_accept = (state == ST_IDLE) && sample_stb;

    // NOTE: snapshot registers carry pure datapath values that are only read after a strobe has
    // loaded them, so they are deliberately left out of the reset network.
    always_ff @(posedge clk_sys) begin
        if (stb_accept) begin
            opll_h   <= opll_i;
            opl3_l_h <= opl3_l_i;
            opl3_r_h <= opl3_r_i;
            scc1_l_h <= scc1_l_i;
            scc1_r_h <= scc1_r_i;
            scc2_l_h <= scc2_l_i;
            scc2_r_h <= scc2_r_i;
            psg_h    <= psg_i;
            pcm_h    <= pcm_i;
            tape_h   <= tape_i;
            mute_h   <= mute_mask;
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        term_l = '0;
        term_r = '0;
        pcm_w  = {pcm_h, pcm_h};
        mute_x = {1'b0, mute_h};
        case (idx)
            3'd0: begin term_l = ACC_W'(opll_h);   term_r = ACC_W'(opll_h);   end
            3'd1: begin term_l = ACC_W'(opl3_l_h); term_r = ACC_W'(opl3_r_h); end
            3'd2: begin term_l = ACC_W'(scc1_l_h); term_r = ACC_W'(scc1_r_h); end
            3'd3: begin term_l = ACC_W'(scc2_l_h); term_r = ACC_W'(scc2_r_h); end
            3'd4: begin
                term_l = ACC_W'(psg_h) << PSG_SHIFT;
                term_r = ACC_W'(psg_h) << PSG_SHIFT;
            end
            3'd5: begin term_l = ACC_W'(pcm_w); term_r = ACC_W'(pcm_w); end
            3'd6: begin
                term_l = ACC_W'({tape_h, 7'b0});
                term_r = ACC_W'({tape_h, 7'b0});
            end
            default: ;
        endcase
        if (mute_x[idx]) begin
            term_l = '0;
            term_r = '0;
        end
    end

    always_comb begin
        sat_l = acc_l[15:0];
        ovf_l = 1'b0;
        if (acc_l > SAT_MAX) begin
            sat_l = 16'sh7FFF;
            ovf_l = 1'b1;
        end else if (acc_l < SAT_MIN) begin
            sat_l = -16'sh8000;
            ovf_l = 1'b1;
        end
        sat_r = acc_r[15:0];
        ovf_r = 1'b0;
        if (acc_r > SAT_MAX) begin
            sat_r = 16'sh7FFF;
            ovf_r = 1'b1;
        end else if (acc_r < SAT_MIN) begin
            sat_r = -16'sh8000;
            ovf_r = 1'b1;
        end
    end

`ifdef AUDIO_MIX_VOL_EN
    logic        [2:0]  vol_h;
    logic signed [15:0] sat_l_q, sat_r_q;
`else
    logic unused_vol;
    assign unused_vol = ^vol_i;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            stb_drop  <= 1'b0;
`ifdef AUDIO_MIX_VOL_EN
            vol_h     <= '0;
            sat_l_q   <= '0;
            sat_r_q   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            // Sets win over a simultaneous clear.
            clip_l   <= ((state == ST_SAT) && ovf_l) || (clip_l && !clip_clr);
            clip_r   <= ((state == ST_SAT) && ovf_r) || (clip_r && !clip_clr);
            stb_drop <= (sample_stb && busy) || (stb_drop && !clip_clr);
            case (state)
                ST_IDLE: begin
                    if (sample_stb) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= ST_ACC;
`ifdef AUDIO_MIX_VOL_EN
                        vol_h <= vol_i;
`endif
                    end
                end
                ST_ACC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7) state <= ST_SAT;
                end
                ST_SAT: begin
`ifdef AUDIO_MIX_VOL_EN
                    sat_l_q <= sat_l;
                    sat_r_q <= sat_r;
                    state   <= ST_VOL;
`else
                    out_l     <= sat_l;
                    out_r     <= sat_r;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
`endif
                end
`ifdef AUDIO_MIX_VOL_EN
                ST_VOL: begin
                    out_l     <= sat_l_q >>> vol_h;
                    out_r     <= sat_r_q >>> vol_h;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
